// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the elastic pipeline stage register.
package pipe_stage_reg_pkg;

  // Occupancy-coded state: the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  // Encoded NOP instruction; presented as the bubble payload.
  localparam logic [31:0] NOP_ENC = 32'h0000_0000;

  // Stage-wrapper control levels used to drive flush and out_ready.
  localparam logic IF_ID_FLUSH_ON  = 1'b1;
  localparam logic IF_ID_FLUSH_OFF = 1'b0;
  localparam logic IF_ID_WRITE_ON  = 1'b1;
  localparam logic IF_ID_WRITE_OFF = 1'b0;

endpackage : pipe_stage_reg_pkg

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module pipe_stage_reg_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise increment until all-ones and stick there.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : pipe_stage_reg_sat_counter

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage with optional 2-entry skid buffer,
// flush, and a saturating backpressure counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(NOP_ENC),
  parameter bit               SKID   = 1'b1,
  parameter int unsigned      CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             stall_inc_s;

  // With SKID the ready is a pure decode of the state register, so no
  // combinational path from out_ready reaches upstream.
  assign out_valid  = (state_q != ST_EMPTY);
  assign in_ready   = SKID ? (state_q != ST_FULL) : (~out_valid | out_ready);
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;
  assign out_data   = main_q;
  assign occupancy  = state_q;

  // Next-state and data movement; flush drops everything including this
  // cycle's transfers. main is kept at BUBBLE whenever the stage is empty.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_d = in_data;
          end else if (in_fire_s) begin
            // Only reachable with SKID: downstream stalled, park in skid.
            if (SKID) begin
              state_d = ST_FULL;
              skid_d  = in_data;
            end else begin
              state_d = ST_ONE;
            end
          end else if (out_fire_s) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // A flush cycle is not a stall; the count survives flushes.
  assign stall_inc_s = in_valid & ~in_ready & ~flush;

  pipe_stage_reg_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear_i (1'b0),
    .inc_i   (stall_inc_s),
    .count_o (stall_cnt)
  );

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: three configurations driven by shared stimulus
// (SKID=1, SKID=0, SKID=1 with CNT_W=2), each checked against a FIFO model.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic [2:0]        d_ir, d_ov;
  logic [2:0][31:0]  d_od;
  logic [2:0][1:0]   d_occ;
  logic [15:0]       st0, st1;
  logic [1:0]        st2;
  logic [31:0]       d_st [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a bounded FIFO per instance plus a saturating stall tally.
  bit          skid_p [3] = '{1'b1, 1'b0, 1'b1};
  longint      smax   [3] = '{65535, 65535, 3};
  int          mcnt   [3];
  logic [31:0] mbuf   [3][2];
  longint      mstall [3];

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .BUBBLE(32'h0), .SKID(1'b1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d_ir[0]),
    .in_data(in_data), .out_valid(d_ov[0]), .out_ready(out_ready), .out_data(d_od[0]),
    .occupancy(d_occ[0]), .stall_cnt(st0));

  pipe_stage_reg #(.WIDTH(32), .BUBBLE(32'h0), .SKID(1'b0), .CNT_W(16)) u_noskid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d_ir[1]),
    .in_data(in_data), .out_valid(d_ov[1]), .out_ready(out_ready), .out_data(d_od[1]),
    .occupancy(d_occ[1]), .stall_cnt(st1));

  pipe_stage_reg #(.WIDTH(32), .BUBBLE(32'h0), .SKID(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(d_ir[2]),
    .in_data(in_data), .out_valid(d_ov[2]), .out_ready(out_ready), .out_data(d_od[2]),
    .occupancy(d_occ[2]), .stall_cnt(st2));

  assign d_st[0] = {16'd0, st0};
  assign d_st[1] = {16'd0, st1};
  assign d_st[2] = {30'd0, st2};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready(input int i, input logic orr);
    if (skid_p[i]) return (mcnt[i] < 2);
    return (mcnt[i] == 0) || orr;
  endfunction

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic r, input logic f, input logic iv, input logic orr,
                       input logic [31:0] id, input bit chk);
    bit ir_m [3];
    rst = r; flush = f; in_valid = iv; out_ready = orr;
    in_data = iv ? id : $urandom();
    #1;
    for (int i = 0; i < 3; i++) begin
      ir_m[i] = m_ready(i, orr);
      if (chk) begin
        check_eq($sformatf("u%0d.in_ready", i), {31'd0, d_ir[i]}, {31'd0, ir_m[i]});
        check_eq($sformatf("u%0d.out_valid", i), {31'd0, d_ov[i]}, {31'd0, mcnt[i] > 0});
        check_eq($sformatf("u%0d.out_data", i), d_od[i], (mcnt[i] > 0) ? mbuf[i][0] : 32'h0);
        check_eq($sformatf("u%0d.occupancy", i), {30'd0, d_occ[i]}, mcnt[i]);
        check_eq($sformatf("u%0d.stall_cnt", i), d_st[i], 32'(mstall[i]));
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        mcnt[i] = 0;
        mstall[i] = 0;
      end else if (f) begin
        mcnt[i] = 0;
      end else begin
        if (iv && !ir_m[i] && mstall[i] < smax[i]) mstall[i]++;
        if (mcnt[i] > 0 && orr) begin
          mbuf[i][0] = mbuf[i][1];
          mcnt[i]--;
        end
        if (iv && ir_m[i]) begin
          mbuf[i][mcnt[i]] = id;
          mcnt[i]++;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'h0;
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0;
      mstall[i] = 0;
    end

    // Reset and idle.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check_eq("rst.in_ready", {31'd0, d_ir[0]}, 32'd1);
    check_eq("rst.out_valid", {31'd0, d_ov[0]}, 32'd0);
    check_eq("rst.stall", d_st[0], 32'd0);

    // Streaming with out_ready=1: one-cycle latency, occupancy 1.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 1'b1);
    check_eq("stream.d0", d_od[0], 32'h11);
    check_eq("stream.occ", {30'd0, d_occ[0]}, 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h22, 1'b1);
    check_eq("stream.d1", d_od[0], 32'h22);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h33, 1'b1);
    check_eq("stream.d2", d_od[0], 32'h33);
    check_eq("stream.stall", d_st[0], 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);

    // Skid fill with downstream stalled, then drain in order.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hA1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hA2, 1'b1);
    check_eq("skid.occ", {30'd0, d_occ[0]}, 32'd2);
    check_eq("skid.in_ready", {31'd0, d_ir[0]}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hA3, 1'b1);
      check_eq("skid.stall", d_st[0], 32'(k));
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'hA3, 1'b1);
    check_eq("skid.drain1", d_od[0], 32'hA2);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'hA3, 1'b1);
    check_eq("skid.drain2", d_od[0], 32'hA3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);

    // Flush while full with a simultaneous input.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hA1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hA2, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'hBB, 1'b1);
    check_eq("flush.out_valid", {31'd0, d_ov[0]}, 32'd0);
    check_eq("flush.occ", {30'd0, d_occ[0]}, 32'd0);
    check_eq("flush.data", d_od[0], 32'h0);
    check_eq("flush.stall", d_st[0], 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
    check_eq("flush.nobb", {31'd0, d_ov[0]}, 32'd0);

    // Combinational ready without skid.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h54, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h55, 1'b1);
    check_eq("noskid.data", d_od[1], 32'h55);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h56, 1'b1);
    check_eq("noskid.hold", d_od[1], 32'h55);
    check_eq("noskid.stall", d_st[1], 32'd1);

    // Saturation of the 2-bit stall counter.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hC1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hC2, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hC3, 1'b1);
      check_eq("sat.stall", d_st[2], (k < 3) ? 32'(k) : 32'd3);
    end

    // Reset while full, then stream immediately.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h99, 1'b1);
    check_eq("midrst.out_valid", {31'd0, d_ov[0]}, 32'd0);
    check_eq("midrst.occ", {30'd0, d_occ[0]}, 32'd0);
    check_eq("midrst.stall", d_st[0], 32'd0);
    check_eq("midrst.in_ready", {31'd0, d_ir[0]}, 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h77, 1'b1);
    check_eq("midrst.data", d_od[0], 32'h77);

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom(), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_stage_reg
